miss_fill_ctrl: RTL and testbench
=================================

# miss_fill_ctrl

Cache-miss fill controller for the 16-bit five-stage pipeline. It arbitrates the single main-memory read port between instruction-cache and data-cache misses, and sequences an 8-word block fill into the winning cache. It also drives the write enables and IF/ID flush of the pipeline registers, so the pipeline freezes or drains while a fill is outstanding.

## Interface
Parameters:
- BLOCK_WORDS, 8, 16-bit words per cache block; fixed, word index is 3 bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- icache_miss  in  1  I-cache miss, level; held until the cycle after fill_done_i
- icache_miss_addr  in  16  byte address of the I-side miss
- dcache_miss  in  1  D-cache miss, level; held until the cycle after fill_done_d
- dcache_miss_addr  in  16  byte address of the D-side miss
- mem_data_valid  in  1  memory returns one word this cycle, in issue order
- mem_en  out  1  read request to memory this cycle
- mem_addr  out  16  read address, valid when mem_en=1
- fill_we  out  1  write the returned word into the target cache
- fill_sel  out  1  fill target: 0 = I-cache, 1 = D-cache
- fill_word  out  3  word index of the returned word
- fill_done_i  out  1  one-cycle pulse: I-side block complete
- fill_done_d  out  1  one-cycle pulse: D-side block complete
- pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write  out  1 each  pipeline register write enables
- if_id_flush  out  1  IF/ID flush; the pipeline register converts the instruction to a NOP

## Operation
- States are IDLE, FILL and DONE.
- **IDLE:**
  - If dcache_miss=1, latch target=D and base = dcache_miss_addr & 16'hFFF0, then go to FILL.
  - Otherwise, if icache_miss=1, do the same with target=I and the I-side address.
  - D-side has fixed priority because it is the older instruction.
- **FILL:**
  - issue_cnt runs 0 to 8. While issue_cnt < 8: mem_en=1, mem_addr = base + {issue_cnt, 1'b0}, then issue_cnt increments.
  - ret_cnt runs 0 to 7. On mem_data_valid=1: fill_we=1, fill_word=ret_cnt, then ret_cnt increments.
  - When mem_data_valid=1 and ret_cnt=7, go to DONE.
- **DONE:**
  - fill_done_i or fill_done_d (per target) is 1 for this cycle only.
  - Go to IDLE.
  - Miss inputs are ignored in DONE.
- fill_sel equals the latched target in FILL and DONE, and 0 in IDLE.
- mem_data_valid outside FILL is ignored.
- Memory latency is at least 1 cycle; a valid never coincides with its own mem_en cycle.
- A miss arriving during FILL or DONE waits; it is granted in the first IDLE cycle in which it is asserted.
- Stall logic is combinational from the miss inputs and the state:
  - d_busy = dcache_miss | (state≠IDLE & target=D)
  - i_busy = icache_miss | (state≠IDLE & target=I)
- Pipeline control outputs:
  - d_busy=1: all five write enables are 0 and if_id_flush=0. The whole pipeline freezes.
  - d_busy=0 and i_busy=1: pc_write=0, if_id_write=1, if_id_flush=1, and the other enables are 1. NOPs enter IF/ID and downstream drains.
  - Neither: all enables are 1 and if_id_flush=0.
- **Reset:**
  - While rst=1, the next state is IDLE and issue_cnt, ret_cnt, target and base clear to 0.
  - While rst=1, outputs are forced: mem_en, mem_addr, fill_we, fill_sel, fill_word, fill_done_i, fill_done_d and if_id_flush are 0, and all write enables are 1.
  - Reset during FILL aborts the fill with no done pulse; returns still in flight are ignored.

## Timing
- A miss seen in IDLE at cycle T means FILL starts at T+1, with mem_en=1 on cycles T+1 to T+8 at addresses base, base+2, …, base+14.
- With memory latency L, fill_we=1 on cycles T+1+L to T+8+L with fill_word 0 to 7.
- DONE and the fill_done pulse occur at T+9+L; IDLE resumes at T+10+L.
- The cache drops its miss at T+10+L. If the miss is still high in that IDLE cycle, a new fill is started (legal, not an error).
- Back-to-back fills: a pending I-miss after a D-fill is granted at T+10+L, with FILL starting at T+11+L.
- Stall outputs respond in the same cycle as the miss inputs, with no added latency.

## Test plan
- **Reset:** hold rst=1 for 2 cycles with both misses high → mem_en=0, all write enables=1, if_id_flush=0; FILL starts the cycle after rst drops.
- **Single D-miss:** dcache_miss_addr=16'h1236, L=4 → mem_addr 16'h1230 to 16'h123E on 8 consecutive cycles; fill_we with fill_word 0 to 7 and fill_sel=1; fill_done_d at T+13; all write enables 0 throughout.
- **Single I-miss:** icache_miss_addr=16'h0042, L=4 → addresses 16'h0040 to 16'h004E; fill_sel=0; pc_write=0 and if_id_flush=1 while the other enables stay 1; fill_done_i at T+13.
- **Simultaneous misses:** both misses rise together → D filled first, then I granted at the IDLE after fill_done_d; the pipeline stays fully frozen until D completes, then enters I-drain mode.
- **Irregular returns:** mem_data_valid gapped (e.g. returns on alternate cycles) plus a spurious valid in IDLE → exactly 8 fill_we pulses with indices 0 to 7 in order; the spurious valid is ignored; DONE follows the 8th return.
- **Reset mid-fill:** rst=1 after the 3rd return → no fill_done pulse, counters cleared; late valids ignored; a new miss restarts at word 0.

Source files
------------

// File: rtl/miss_fill_ctrl.sv
// Cache-miss fill controller: arbitrates the single memory read port between
// I-cache and D-cache misses, sequences an 8-word block fill into the winning
// cache, and freezes or drains the pipeline while a fill is outstanding.
module miss_fill_ctrl #(
    parameter int BLOCK_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_miss,
    input  logic [15:0] icache_miss_addr,
    input  logic        dcache_miss,
    input  logic [15:0] dcache_miss_addr,
    input  logic        mem_data_valid,
    output logic        mem_en,
    output logic [15:0] mem_addr,
    output logic        fill_we,
    output logic        fill_sel,
    output logic [2:0]  fill_word,
    output logic        fill_done_i,
    output logic        fill_done_d,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_write,
    output logic        ex_mem_write,
    output logic        mem_wb_write,
    output logic        if_id_flush
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    // Issue counter needs one extra value (0..8) to mark "all requests sent".
    localparam logic [3:0] ISSUE_END = 4'(BLOCK_WORDS);
    localparam logic [2:0] RET_LAST  = 3'(BLOCK_WORDS - 1);

    state_t      state_q, state_d;
    logic        target_q, target_d;      // 0 = I-cache, 1 = D-cache
    logic [15:0] base_q, base_d;
    logic [3:0]  issue_cnt_q, issue_cnt_d;
    logic [2:0]  ret_cnt_q, ret_cnt_d;

    logic        d_busy;
    logic        i_busy;

    // State and fill bookkeeping registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            target_q    <= 1'b0;
            base_q      <= 16'h0000;
            issue_cnt_q <= 4'd0;
            ret_cnt_q   <= 3'd0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
        end
    end

    // Next-state, memory/fill outputs and pipeline stall control.
    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        base_d       = base_q;
        issue_cnt_d  = issue_cnt_q;
        ret_cnt_d    = ret_cnt_q;
        mem_en       = 1'b0;
        mem_addr     = 16'h0000;
        fill_we      = 1'b0;
        fill_word    = 3'd0;
        fill_done_i  = 1'b0;
        fill_done_d  = 1'b0;
        fill_sel     = 1'b0;

        case (state_q)
            IDLE: begin
                // D-side wins: it belongs to the older instruction.
                if (dcache_miss) begin
                    target_d    = 1'b1;
                    base_d      = dcache_miss_addr & 16'hFFF0;
                    issue_cnt_d = 4'd0;
                    ret_cnt_d   = 3'd0;
                    state_d     = FILL;
                end else if (icache_miss) begin
                    target_d    = 1'b0;
                    base_d      = icache_miss_addr & 16'hFFF0;
                    issue_cnt_d = 4'd0;
                    ret_cnt_d   = 3'd0;
                    state_d     = FILL;
                end
            end
            FILL: begin
                fill_sel = target_q;
                if (issue_cnt_q < ISSUE_END) begin
                    mem_en      = 1'b1;
                    mem_addr    = base_q + {11'd0, issue_cnt_q, 1'b0};
                    issue_cnt_d = issue_cnt_q + 4'd1;
                end
                if (mem_data_valid) begin
                    fill_we   = 1'b1;
                    fill_word = ret_cnt_q;
                    ret_cnt_d = ret_cnt_q + 3'd1;
                    if (ret_cnt_q == RET_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                fill_sel    = target_q;
                fill_done_d = target_q;
                fill_done_i = ~target_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        d_busy = dcache_miss | ((state_q != IDLE) & target_q);
        i_busy = icache_miss | ((state_q != IDLE) & ~target_q);

        // D-miss freezes everything; I-miss alone drains NOPs downstream.
        pc_write     = ~(d_busy | i_busy);
        if_id_write  = ~d_busy;
        id_ex_write  = ~d_busy;
        ex_mem_write = ~d_busy;
        mem_wb_write = ~d_busy;
        if_id_flush  = ~d_busy & i_busy;

        if (rst) begin
            mem_en       = 1'b0;
            mem_addr     = 16'h0000;
            fill_we      = 1'b0;
            fill_sel     = 1'b0;
            fill_word    = 3'd0;
            fill_done_i  = 1'b0;
            fill_done_d  = 1'b0;
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
            mem_wb_write = 1'b1;
            if_id_flush  = 1'b0;
        end
    end

endmodule

// File: tb/tb_miss_fill_ctrl.sv
// Self-checking bench for miss_fill_ctrl: a behavioural memory with
// configurable latency, a reference model of the fill sequence and stall
// rules, and scoreboards of expected read addresses and fill word indices.
module tb_miss_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_miss;
    logic [15:0] icache_miss_addr;
    logic        dcache_miss;
    logic [15:0] dcache_miss_addr;
    logic        mem_data_valid;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic        fill_we;
    logic        fill_sel;
    logic [2:0]  fill_word;
    logic        fill_done_i;
    logic        fill_done_d;
    logic        pc_write;
    logic        if_id_write;
    logic        id_ex_write;
    logic        ex_mem_write;
    logic        mem_wb_write;
    logic        if_id_flush;

    miss_fill_ctrl #(.BLOCK_WORDS(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .icache_miss      (icache_miss),
        .icache_miss_addr (icache_miss_addr),
        .dcache_miss      (dcache_miss),
        .dcache_miss_addr (dcache_miss_addr),
        .mem_data_valid   (mem_data_valid),
        .mem_en           (mem_en),
        .mem_addr         (mem_addr),
        .fill_we          (fill_we),
        .fill_sel         (fill_sel),
        .fill_word        (fill_word),
        .fill_done_i      (fill_done_i),
        .fill_done_d      (fill_done_d),
        .pc_write         (pc_write),
        .if_id_write      (if_id_write),
        .id_ex_write      (id_ex_write),
        .ex_mem_write     (ex_mem_write),
        .mem_wb_write     (mem_wb_write),
        .if_id_flush      (if_id_flush)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Bench state: cycle number, memory model, reference model, scoreboards.
    int          cyc = 0;
    int          lat = 4;
    bit          gapped = 1'b0;
    logic        force_valid = 1'b0;
    int          mq[$];            // issue cycles of outstanding reads
    logic [15:0] ea_q[$];          // expected read addresses
    logic [2:0]  ew_q[$];          // expected fill word indices
    int          m_state = 0;      // 0 IDLE, 1 FILL, 2 DONE
    logic        m_tgt = 1'b0;
    int          m_issue = 0;
    int          m_ret = 0;
    int          grant_cyc = -1;
    int          first_en_cyc = -1;
    int          done_cyc = -1;
    int          done_cnt = 0;
    int          we_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_grant(input logic tgt, input logic [15:0] addr);
        logic [15:0] base;
        base      = addr & 16'hFFF0;
        m_state   = 1;
        m_tgt     = tgt;
        m_issue   = 0;
        m_ret     = 0;
        grant_cyc = cyc;
        for (int k = 0; k < 8; k++) begin
            ea_q.push_back(base + 16'(2 * k));
            ew_q.push_back(3'(k));
        end
    endtask

    // One clock cycle: drive memory return, check outputs at negedge, advance model.
    task automatic cycle();
        logic [5:0] exp_pipe;
        logic [1:0] exp_done;
        logic       exp_en, exp_we, exp_sel, d_busy, i_busy, from_q;
        from_q = 1'b0;
        if (mq.size() > 0) begin
            if (cyc >= mq[0] + lat && (!gapped || (cyc % 2) == 0)) from_q = 1'b1;
        end
        mem_data_valid = from_q | force_valid;
        @(negedge clk);
        if (rst) begin
            exp_pipe = 6'b111110;
            exp_en   = 1'b0;
            exp_we   = 1'b0;
            exp_sel  = 1'b0;
            exp_done = 2'b00;
        end else begin
            d_busy   = dcache_miss | (m_state != 0 && m_tgt);
            i_busy   = icache_miss | (m_state != 0 && !m_tgt);
            exp_pipe = d_busy ? 6'b000000 : (i_busy ? 6'b011111 : 6'b111110);
            exp_en   = (m_state == 1 && m_issue < 8);
            exp_we   = (m_state == 1 && mem_data_valid);
            exp_sel  = (m_state != 0) && m_tgt;
            exp_done = (m_state == 2) ? (m_tgt ? 2'b10 : 2'b01) : 2'b00;
        end
        chk("pipe_ctrl", {26'd0, pc_write, if_id_write, id_ex_write, ex_mem_write,
                          mem_wb_write, if_id_flush}, {26'd0, exp_pipe});
        chk("mem_en", {31'd0, mem_en}, {31'd0, exp_en});
        chk("fill_we", {31'd0, fill_we}, {31'd0, exp_we});
        chk("fill_sel", {31'd0, fill_sel}, {31'd0, exp_sel});
        chk("fill_done", {30'd0, fill_done_d, fill_done_i}, {30'd0, exp_done});
        if (rst) chk("rst_outs", {16'd0, mem_addr}, 32'd0);
        if (mem_en && exp_en) begin
            if (ea_q.size() == 0) chk("addr_q_empty", 32'd1, 32'd0);
            else chk("mem_addr", {16'd0, mem_addr}, {16'd0, ea_q.pop_front()});
        end
        if (fill_we && exp_we) begin
            if (ew_q.size() == 0) chk("word_q_empty", 32'd1, 32'd0);
            else chk("fill_word", {29'd0, fill_word}, {29'd0, ew_q.pop_front()});
        end
        // Memory model and event bookkeeping from observed DUT behaviour.
        if (mem_en) begin
            mq.push_back(cyc);
            if (first_en_cyc < 0) first_en_cyc = cyc;
        end
        if (from_q) void'(mq.pop_front());
        if (fill_we) we_cnt++;
        if (fill_done_i || fill_done_d) begin
            done_cnt++;
            done_cyc = cyc;
        end
        // Reference model transition.
        if (rst) begin
            m_state = 0;
            m_tgt   = 1'b0;
            m_issue = 0;
            m_ret   = 0;
            ea_q.delete();
            ew_q.delete();
        end else begin
            case (m_state)
                0: begin
                    if (dcache_miss) model_grant(1'b1, dcache_miss_addr);
                    else if (icache_miss) model_grant(1'b0, icache_miss_addr);
                end
                1: begin
                    if (m_issue < 8) m_issue++;
                    if (mem_data_valid) begin
                        m_ret++;
                        if (m_ret == 8) m_state = 2;
                    end
                end
                default: m_state = 0;
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_done(input int maxc, input string tag);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < maxc) begin
            cycle();
            n++;
        end
        if (done_cnt == d0) chk(tag, 32'd0, 32'd1);
    endtask

    initial begin
        int t0;
        int d0;
        int n;
        rst              = 1'b1;
        icache_miss      = 1'b1;
        icache_miss_addr = 16'h2468;
        dcache_miss      = 1'b1;
        dcache_miss_addr = 16'h8ACE;
        mem_data_valid   = 1'b0;

        // Reset with both misses high, then simultaneous-miss arbitration.
        lat = 2;
        cycle();
        cycle();
        rst          = 1'b0;
        first_en_cyc = -1;
        t0           = cyc;
        we_cnt       = 0;
        wait_done(40, "sim_d_timeout");
        chk("rst_fill_start", 32'(first_en_cyc - t0), 32'd1);
        chk("sim_d_first", {31'd0, fill_sel}, 32'd0);
        dcache_miss = 1'b0;
        wait_done(40, "sim_i_timeout");
        icache_miss = 1'b0;
        chk("sim_we_cnt", 32'(we_cnt), 32'd16);
        cycle();

        // Single D-miss, latency 4.
        lat              = 4;
        dcache_miss_addr = 16'h1236;
        dcache_miss      = 1'b1;
        t0               = cyc;
        first_en_cyc     = -1;
        we_cnt           = 0;
        wait_done(40, "d_timeout");
        chk("d_done_lat", 32'(done_cyc - t0), 32'd13);
        chk("d_first_en", 32'(first_en_cyc - t0), 32'd1);
        chk("d_we_cnt", 32'(we_cnt), 32'd8);
        dcache_miss = 1'b0;
        cycle();

        // Single I-miss, latency 4.
        icache_miss_addr = 16'h0042;
        icache_miss      = 1'b1;
        t0               = cyc;
        first_en_cyc     = -1;
        we_cnt           = 0;
        wait_done(40, "i_timeout");
        chk("i_done_lat", 32'(done_cyc - t0), 32'd13);
        chk("i_first_en", 32'(first_en_cyc - t0), 32'd1);
        chk("i_we_cnt", 32'(we_cnt), 32'd8);
        icache_miss = 1'b0;
        cycle();

        // Irregular returns plus a spurious valid while idle.
        lat         = 1;
        gapped      = 1'b1;
        we_cnt      = 0;
        force_valid = 1'b1;
        cycle();
        force_valid = 1'b0;
        chk("spurious_we", 32'(we_cnt), 32'd0);
        icache_miss_addr = 16'hABCD;
        icache_miss      = 1'b1;
        wait_done(80, "gap_timeout");
        chk("gap_we_cnt", 32'(we_cnt), 32'd8);
        icache_miss = 1'b0;
        gapped      = 1'b0;
        cycle();

        // Reset after the third return, late returns, then a fresh fill.
        lat              = 3;
        dcache_miss_addr = 16'h5558;
        dcache_miss      = 1'b1;
        we_cnt           = 0;
        n                = 0;
        while (we_cnt < 3 && n < 40) begin
            cycle();
            n++;
        end
        chk("mid_we3", 32'(we_cnt), 32'd3);
        d0          = done_cnt;
        rst         = 1'b1;
        dcache_miss = 1'b0;
        cycle();
        rst = 1'b0;
        n   = 0;
        while (mq.size() > 0 && n < 20) begin
            cycle();
            n++;
        end
        cycle();
        cycle();
        chk("mid_no_done", 32'(done_cnt), 32'(d0));
        chk("mid_late_ignored", 32'(we_cnt), 32'd3);
        icache_miss_addr = 16'h0100;
        icache_miss      = 1'b1;
        we_cnt           = 0;
        wait_done(40, "restart_timeout");
        chk("restart_we_cnt", 32'(we_cnt), 32'd8);
        icache_miss = 1'b0;
        cycle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=finish", cyc);
        $fatal(1, "global timeout");
    end

endmodule
